// File: rtl/fifo_mem_if.sv
// Producer/consumer handshake and status bundle for fifo_mem.
// master = the client driving strobes/data, slave = the FIFO itself.
interface fifo_mem_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  trans_write;
  logic                  trans_read;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full_ind;
  logic                  empty_ind;
  logic                  overflow_ind;
  logic                  underflow_ind;
  logic                  threshold_ind;

  modport master (
    output trans_write, trans_read, data_in,
    input  data_out, full_ind, empty_ind, overflow_ind, underflow_ind, threshold_ind
  );

  modport slave (
    input  trans_write, trans_read, data_in,
    output data_out, full_ind, empty_ind, overflow_ind, underflow_ind, threshold_ind
  );
endinterface

// File: rtl/fifo_mem.sv
// Single-clock first-word-fall-through FIFO with full/empty/threshold/overflow/underflow flags.
// Optional macro FIFO_STICKY_FLAGS_EN makes overflow/underflow sticky until reset.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned OSTD_NUM        = 8,
  parameter int unsigned THRESHOLD_VALUE = OSTD_NUM / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  fifo_mem_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(OSTD_NUM);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [OSTD_NUM];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  overflow_q;
  logic                  underflow_q;

  logic full_c;
  logic empty_c;
  logic wr_acc_c;
  logic rd_acc_c;
  logic ovf_set_c;
  logic udf_set_c;

  assign full_c    = (count == CNT_W'(OSTD_NUM));
  assign empty_c   = (count == '0);
  // A write into a full FIFO is still taken when a pop frees the head slot on the same edge.
  assign wr_acc_c  = bus.trans_write & (~full_c | bus.trans_read);
  assign rd_acc_c  = bus.trans_read & ~empty_c;
  assign ovf_set_c = bus.trans_write & full_c & ~bus.trans_read;
  assign udf_set_c = bus.trans_read & empty_c;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_acc_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_acc_c, rd_acc_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Error flags: one-cycle pulses by default, sticky until reset when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
`ifdef FIFO_STICKY_FLAGS_EN
      overflow_q  <= overflow_q | ovf_set_c;
      underflow_q <= underflow_q | udf_set_c;
`else
      overflow_q  <= ovf_set_c;
      underflow_q <= udf_set_c;
`endif
    end
  end

  assign bus.data_out      = empty_c ? '0 : mem[rd_ptr];
  assign bus.full_ind      = full_c;
  assign bus.empty_ind     = empty_c;
  assign bus.threshold_ind = (count >= CNT_W'(THRESHOLD_VALUE));
  assign bus.overflow_ind  = overflow_q;
  assign bus.underflow_ind = underflow_q;

endmodule

// File: tb/tb_fifo_mem.sv
// Randomized and directed bench for fifo_mem, checked every cycle against a queue-based model.
module tb_fifo_mem;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned THR   = 4;
`ifdef FIFO_STICKY_FLAGS_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  fifo_mem_if #(.DATA_WIDTH(DW)) bus ();

  fifo_mem #(
    .DATA_WIDTH      (DW),
    .OSTD_NUM        (DEPTH),
    .THRESHOLD_VALUE (THR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the FIFO contents as a plain queue.
  logic [DW-1:0] q[$];
  bit            m_ovf;
  bit            m_udf;
  bit            mw;
  bit            mr;
  bit            m_full;
  bit            m_empty;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      mw      = bus.trans_write;
      mr      = bus.trans_read;
      m_full  = (q.size() == DEPTH);
      m_empty = (q.size() == 0);
      m_ovf   = (STICKY && m_ovf) || (mw && m_full && !mr);
      m_udf   = (STICKY && m_udf) || (mr && m_empty);
      if (mr && !m_empty) void'(q.pop_front());
      if (mw && (!m_full || mr)) q.push_back(bus.data_in);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cmp_data_out",  32'(bus.data_out),      (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk("cmp_full",      32'(bus.full_ind),      32'(q.size() == DEPTH));
    chk("cmp_empty",     32'(bus.empty_ind),     32'(q.size() == 0));
    chk("cmp_threshold", 32'(bus.threshold_ind), 32'(q.size() >= THR));
    chk("cmp_overflow",  32'(bus.overflow_ind),  32'(m_ovf));
    chk("cmp_underflow", 32'(bus.underflow_ind), 32'(m_udf));
  end

  task automatic cyc(input bit w, input bit r, input logic [DW-1:0] d);
    bus.trans_write = w;
    bus.trans_read  = r;
    bus.data_in     = d;
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.trans_write = 1'b0;
    bus.trans_read  = 1'b0;
    bus.data_in     = '0;

    // Reset with random strobes.
    repeat (2) cyc(1'($urandom), 1'($urandom), DW'($urandom));
    chk("rst_empty", 32'(bus.empty_ind), 32'd1);
    chk("rst_full",  32'(bus.full_ind),  32'd0);
    chk("rst_thr",   32'(bus.threshold_ind), 32'd0);
    chk("rst_ovf",   32'(bus.overflow_ind),  32'd0);
    chk("rst_udf",   32'(bus.underflow_ind), 32'd0);
    chk("rst_dout",  32'(bus.data_out), 32'd0);
    bus.trans_write = 1'b0;
    bus.trans_read  = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Fill.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, DW'(i));
      if (i == 3) chk("fill_thr_3", 32'(bus.threshold_ind), 32'd0);
      if (i == 4) chk("fill_thr_4", 32'(bus.threshold_ind), 32'd1);
      if (i == 7) chk("fill_full_7", 32'(bus.full_ind), 32'd0);
      if (i == 8) chk("fill_full_8", 32'(bus.full_ind), 32'd1);
    end
    chk("fill_head", 32'(bus.data_out), 32'h0001);

    // Overflow.
    cyc(1'b1, 1'b0, 16'h0009);
    chk("ovf_pulse", 32'(bus.overflow_ind), 32'd1);
    chk("ovf_full",  32'(bus.full_ind), 32'd1);
    cyc(1'b0, 1'b0, '0);
    chk("ovf_after", 32'(bus.overflow_ind), 32'(STICKY));

    // Drain.
    for (int i = 1; i <= 8; i++) begin
      chk("drain_data", 32'(bus.data_out), 32'(i));
      cyc(1'b0, 1'b1, '0);
    end
    chk("drain_empty", 32'(bus.empty_ind), 32'd1);

    // Underflow.
    cyc(1'b0, 1'b1, '0);
    chk("udf_pulse", 32'(bus.underflow_ind), 32'd1);
    chk("udf_empty", 32'(bus.empty_ind), 32'd1);
    chk("udf_dout",  32'(bus.data_out), 32'd0);
    cyc(1'b0, 1'b0, '0);
    chk("udf_after", 32'(bus.underflow_ind), 32'(STICKY));

    // Simultaneous read+write on empty.
    cyc(1'b1, 1'b1, 16'h0055);
    chk("rw_empty_dout", 32'(bus.data_out), 32'h0055);
    chk("rw_empty_udf",  32'(bus.underflow_ind), 32'd1);
    chk("rw_empty_nempty", 32'(bus.empty_ind), 32'd0);
    cyc(1'b0, 1'b1, '0);

    // Simultaneous read+write on full.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, DW'(16'h0010 + i));
    cyc(1'b1, 1'b1, 16'h00AA);
    chk("rw_full_full", 32'(bus.full_ind), 32'd1);
    chk("rw_full_head", 32'(bus.data_out), 32'h0011);
    chk("rw_full_ovf",  32'(bus.overflow_ind), 32'(STICKY));
    for (int i = 1; i < 8; i++) begin
      chk("rw_full_drain", 32'(bus.data_out), 32'(16'h0010 + i));
      cyc(1'b0, 1'b1, '0);
    end
    chk("rw_full_last", 32'(bus.data_out), 32'h00AA);
    cyc(1'b0, 1'b1, '0);

    // Wrap-around: 17 write/read pairs.
    for (int k = 0; k < 17; k++) begin
      cyc(1'b1, 1'b0, DW'(16'h0100 + k));
      chk("wrap_data", 32'(bus.data_out), 32'(16'h0100 + k));
      cyc(1'b0, 1'b1, '0);
    end
    chk("wrap_empty", 32'(bus.empty_ind), 32'd1);

    // Async reset mid-burst with three words stored.
    cyc(1'b1, 1'b0, 16'h00A1);
    cyc(1'b1, 1'b0, 16'h00A2);
    cyc(1'b1, 1'b0, 16'h00A3);
    chk("pre_rst_head", 32'(bus.data_out), 32'h00A1);
    chk("pre_rst_thr",  32'(bus.threshold_ind), 32'd0);
    bus.trans_write = 1'b1;
    bus.data_in     = 16'h00A4;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_empty", 32'(bus.empty_ind), 32'd1);
    chk("arst_full",  32'(bus.full_ind), 32'd0);
    chk("arst_dout",  32'(bus.data_out), 32'd0);
    chk("arst_ovf",   32'(bus.overflow_ind), 32'd0);
    chk("arst_udf",   32'(bus.underflow_ind), 32'd0);
    @(negedge clk);
    bus.trans_write = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Random traffic with alternating fill/drain bias.
    for (int ph = 0; ph < 8; ph++) begin
      int unsigned wp;
      wp = (ph % 2 == 0) ? 75 : 25;
      for (int n = 0; n < 250; n++) begin
        cyc(1'($urandom_range(99) < wp), 1'($urandom_range(99) < (100 - wp)), DW'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
